sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter that shares the single-port, one-cycle-latency `sram` between instruction fetch (IF) and load/store (LS). It sits between the core's fetch and memory stages and the `sram` instance. It issues at most one access per cycle and routes the registered read data back to the granted requester one cycle later. LS has fixed priority, bounded by a starvation guard that forces an IF grant.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive cycles IF may be held off while requesting before it gets a forced grant. Legal range 1..15.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `if_req_valid`  in  1  IF read request
- `if_req_addr`  in  64  IF byte address
- `if_req_ready`  out  1  IF request granted this cycle
- `if_resp_valid`  out  1  IF read data valid
- `if_resp_data`  out  64  IF read data
- `ls_req_valid`  in  1  LS request
- `ls_req_addr`  in  64  LS byte address
- `ls_req_we`  in  8  LS byte write enables; 0 means read
- `ls_req_wdata`  in  64  LS write data
- `ls_req_ready`  out  1  LS request granted this cycle
- `ls_resp_valid`  out  1  LS read data valid, or write acknowledge
- `ls_resp_data`  out  64  LS read data
- `mem_en`  out  1  sram enable
- `mem_we`  out  8  sram byte write enables
- `mem_addr`  out  64  sram address
- `mem_wdata`  out  64  sram write data
- `mem_rdata`  in  64  sram registered read data

## Operation
- Grant logic is combinational from the valids and the starvation counter.
  - `grant_if` = `if_req_valid` & (!`ls_req_valid` | `starve_cnt` == `STARVE_LIMIT`).
  - `grant_ls` = `ls_req_valid` & !`grant_if`.
  - The two grants are mutually exclusive.
- `if_req_ready` = `grant_if`; `ls_req_ready` = `grant_ls`. A request fires when valid & ready.
- Requesters hold valid, addr, we and wdata stable until ready. The block never latches request fields.
- Memory drive, when the cycle is granted:
  - `mem_en` = `grant_if` | `grant_ls`.
  - `mem_addr` comes from the granted port.
  - `mem_we` = `ls_req_we` on an LS grant, else 0.
  - `mem_wdata` = `ls_req_wdata`.
- Memory drive, when nothing is granted: `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Starvation counter `starve_cnt` (4 bits):
  - Increments on each cycle with `if_req_valid` & !`grant_if`.
  - Saturates at `STARVE_LIMIT`.
  - Clears on `grant_if` or when `if_req_valid`=0.
- Response tracking register `resp_sel` has states NONE, IF, LS.
  - Next state is IF on `grant_if`, LS on `grant_ls`, else NONE.
  - Loads every cycle, so back-to-back issues pipeline with no bubble.
- Responses:
  - `if_resp_valid` = (`resp_sel`==IF). `ls_resp_valid` = (`resp_sel`==LS).
  - Both `*_resp_data` = `mem_rdata`.
  - For LS writes, `ls_resp_valid` is an acknowledge and the data is don't-care.
- Responses have no backpressure; requesters must accept them.

## Timing
- Reset values: `starve_cnt`=0, `resp_sel`=NONE. Hence `if_resp_valid`=0, `ls_resp_valid`=0, and all `mem_*` outputs are 0 while valids are low.
- Latency: a request granted in cycle N gets its response in cycle N+1. The sram write takes effect at the edge ending cycle N.
- Throughput is one access per cycle, with any interleaving of IF and LS.
- Simultaneous requests: LS wins unless `starve_cnt`==`STARVE_LIMIT`. IF is therefore granted no later than the (`STARVE_LIMIT`+1)-th cycle of continuous contention.
- Reset asserted while `resp_sel`!=NONE: the pending response is dropped and no resp_valid appears after reset. Reset has priority over all updates.
- A read of an address written in the previous cycle returns the new data, provided by sram ordering; the arbiter adds no forwarding.

## Test plan
- Idle then IF read of `0x8000_0000`: `if_req_ready`=1 and `mem_en`=1 in cycle N. In N+1, `if_resp_valid`=1 and `if_resp_data` = the preloaded word; `ls_resp_valid` stays 0.
- LS write: `we`=`0xFF`, `wdata`=`0xDEADBEEF_CAFEF00D` to `0x8000_0010`. Then LS read of the same address next cycle: ack in N+1, read data `0xDEADBEEF_CAFEF00D` in N+2.
- Byte write: `we`=`0x01`, `wdata`=`0xAA` over a word preloaded as all-ones. Readback = `0xFFFF_FFFF_FFFF_FFAA`.
- Both valid continuously, `STARVE_LIMIT`=4: grants follow LS,LS,LS,LS,IF, repeating. Each response lands on the matching port one cycle after its grant.
- Reset asserted in the cycle after an IF grant: no `if_resp_valid` pulse; after release, `starve_cnt`=0 and all outputs are idle.
- Random back-to-back mix over 10k cycles against a scoreboard memory model: every response matches and no valid goes to the wrong port.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port, one-cycle-latency sram between
// instruction fetch (IF) and load/store (LS). LS has fixed priority, but a
// starvation counter forces an IF grant after STARVE_LIMIT held-off cycles.
// The read data is routed back to whichever port was granted in the
// previous cycle.
//
// resp_sel state | meaning
// ---------------+-------------------------------------------------
// RESP_NONE      | no access issued last cycle, no response due
// RESP_IF        | IF access issued last cycle, mem_rdata is IF's
// RESP_LS        | LS access issued last cycle, read data or write ack
module sram_arbiter #(
    // Legal range 1..15; the counter is 4 bits wide.
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    input  logic [63:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [63:0] if_resp_data,
    input  logic        ls_req_valid,
    input  logic [63:0] ls_req_addr,
    input  logic [7:0]  ls_req_we,
    input  logic [63:0] ls_req_wdata,
    output logic        ls_req_ready,
    output logic        ls_resp_valid,
    output logic [63:0] ls_resp_data,
    output logic        mem_en,
    output logic [7:0]  mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_LS   = 2'd2
    } resp_sel_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic       grant_if;
    logic       grant_ls;
    logic       starved;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;
    resp_sel_t  resp_sel;
    resp_sel_t  resp_sel_next;

    // Grant decision: LS wins unless IF has been held off long enough.
    // Nothing is issued while reset is asserted so no sram write can slip in.
    always_comb begin
        starved  = (starve_cnt == STARVE_MAX);
        grant_if = rst_n & if_req_valid & (~ls_req_valid | starved);
        grant_ls = rst_n & ls_req_valid & ~grant_if;
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    // Memory drive: the granted port's fields, all zero on an idle cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 8'h00;
        mem_addr  = 64'h0;
        mem_wdata = 64'h0;
        if (grant_if) begin
            mem_en    = 1'b1;
            mem_addr  = if_req_addr;
            mem_wdata = ls_req_wdata;
        end else if (grant_ls) begin
            mem_en    = 1'b1;
            mem_we    = ls_req_we;
            mem_addr  = ls_req_addr;
            mem_wdata = ls_req_wdata;
        end
    end

    // Starvation counter next value: counts IF hold-off cycles, saturating.
    always_comb begin
        starve_cnt_next = 4'd0;
        if (if_req_valid && !grant_if) begin
            if (starved) begin
                starve_cnt_next = STARVE_MAX;
            end else begin
                starve_cnt_next = starve_cnt + 4'd1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_cnt_next;
        end
    end

    // Response tracker state register; reloads every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_sel <= RESP_NONE;
        end else begin
            resp_sel <= resp_sel_next;
        end
    end

    // Response tracker next state: remembers who owns next cycle's rdata.
    always_comb begin
        resp_sel_next = RESP_NONE;
        if (grant_if) begin
            resp_sel_next = RESP_IF;
        end else if (grant_ls) begin
            resp_sel_next = RESP_LS;
        end
    end

    // Response steering; a response pending when reset arrives is dropped.
    always_comb begin
        if_resp_valid = rst_n & (resp_sel == RESP_IF);
        ls_resp_valid = rst_n & (resp_sel == RESP_LS);
        if_resp_data  = mem_rdata;
        ls_resp_data  = mem_rdata;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: behavioural sram, reference memory and a
// response scoreboard, plus directed scenario tasks and a random mix.
module tb_sram_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam logic [63:0] ONES_ADDR = 64'h8000_0020;

    typedef struct {
        bit          is_if;
        bit          is_wr;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [63:0] if_resp_data;
    logic        ls_req_valid;
    logic [63:0] ls_req_addr;
    logic [7:0]  ls_req_we;
    logic [63:0] ls_req_wdata;
    logic        ls_req_ready;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_data;
    logic        mem_en;
    logic [7:0]  mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        sram_load;

    logic [63:0] sram_mem [64];
    logic [63:0] ref_mem  [64];
    exp_t        sb_q [$];

    int total;
    int bad;

    // monitor-private state
    exp_t        m_e;
    bit          m_gi;
    bit          m_gl;
    int unsigned m_cnt;
    logic [63:0] m_addr;
    logic [7:0]  m_we;
    bit          m_en;

    sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid),
        .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr),
        .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata),
        .ls_req_ready(ls_req_ready), .ls_resp_valid(ls_resp_valid),
        .ls_resp_data(ls_resp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input logic [63:0] addr);
        if (addr[63:3] == ONES_ADDR[63:3]) return 64'hFFFF_FFFF_FFFF_FFFF;
        return {addr[31:0] ^ 32'h5A5A_1234, ~addr[31:0]};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_w,
                                          input logic [63:0] wd,
                                          input logic [7:0] we);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural sram: registered read, byte-masked write, 64-word window.
    always @(posedge clk) begin
        if (sram_load) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= init_word(BASE + 64'(i * 8));
        end else if (mem_en) begin
            mem_rdata <= sram_mem[mem_addr[8:3]];
            if (mem_we != 8'h00)
                sram_mem[mem_addr[8:3]] <= merge(sram_mem[mem_addr[8:3]], mem_wdata, mem_we);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        if_req_addr  = 64'h0;
        ls_req_valid = 1'b0;
        ls_req_addr  = 64'h0;
        ls_req_we    = 8'h00;
        ls_req_wdata = 64'h0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sram_load = 1'b1;
        idle_inputs();
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({if_resp_valid, ls_resp_valid} !== 2'b00) begin
                bad++;
                $display("FAIL reset_resp got=%b want=00", {if_resp_valid, ls_resp_valid});
            end
        end
        cyc();
        rst_n     = 1'b1;
        sram_load = 1'b0;
        @(negedge clk);
        total++;
        if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_en, mem_we,
             mem_addr, mem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_idle en=%b we=%h addr=%h wd=%h want all zero",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_if_read();
        cyc();
        if_req_valid = 1'b1;
        if_req_addr  = BASE;
        @(negedge clk);
        total++;
        if ({if_req_ready, mem_en} !== 2'b11) begin
            bad++;
            $display("FAIL if_grant got ready=%b en=%b want 1 1", if_req_ready, mem_en);
        end
        cyc();
        if_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({if_resp_valid, ls_resp_valid} !== 2'b10 || if_resp_data !== init_word(BASE)) begin
            bad++;
            $display("FAIL if_read got v=%b%b d=%h want 10 %h", if_resp_valid, ls_resp_valid,
                     if_resp_data, init_word(BASE));
        end
    endtask

    task automatic test_ls_write_read();
        cyc();
        ls_req_valid = 1'b1;
        ls_req_addr  = BASE + 64'h10;
        ls_req_we    = 8'hFF;
        ls_req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        cyc();
        ls_req_we    = 8'h00;
        ls_req_wdata = 64'h0;
        @(negedge clk);
        total++;
        if (ls_resp_valid !== 1'b1 || if_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL ls_wr_ack got ls=%b if=%b want 1 0", ls_resp_valid, if_resp_valid);
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        total++;
        if (ls_resp_valid !== 1'b1 || ls_resp_data !== 64'hDEAD_BEEF_CAFE_F00D) begin
            bad++;
            $display("FAIL ls_rd_after_wr got v=%b d=%h want 1 deadbeefcafef00d",
                     ls_resp_valid, ls_resp_data);
        end
    endtask

    task automatic test_byte_write();
        cyc();
        ls_req_valid = 1'b1;
        ls_req_addr  = ONES_ADDR;
        ls_req_we    = 8'h01;
        ls_req_wdata = 64'hAA;
        cyc();
        ls_req_we    = 8'h00;
        ls_req_wdata = 64'h0;
        cyc();
        idle_inputs();
        @(negedge clk);
        total++;
        if (ls_resp_valid !== 1'b1 || ls_resp_data !== 64'hFFFF_FFFF_FFFF_FFAA) begin
            bad++;
            $display("FAIL byte_write got v=%b d=%h want 1 ffffffffffffffaa",
                     ls_resp_valid, ls_resp_data);
        end
    endtask

    task automatic contend(input string name);
        cyc();
        if_req_valid = 1'b1;
        if_req_addr  = BASE + 64'h8;
        ls_req_valid = 1'b1;
        ls_req_addr  = BASE + 64'h100;
        ls_req_we    = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({if_req_ready, ls_req_ready} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL %s cycle=%0d got if/ls=%b%b want %s", name, i,
                         if_req_ready, ls_req_ready, (i % 5 == 4) ? "10" : "01");
            end
            if (i != 9) cyc();
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_starvation();
        contend("starve_pattern");
    endtask

    task automatic test_reset_midflight();
        cyc();
        if_req_valid = 1'b1;
        if_req_addr  = BASE + 64'h18;
        cyc();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (if_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_drop got if_resp_valid=%b want 0", if_resp_valid);
        end
        cyc();
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({if_resp_valid, ls_resp_valid, mem_en} !== 3'b000) begin
                bad++;
                $display("FAIL rst_after got if=%b ls=%b en=%b want 000",
                         if_resp_valid, ls_resp_valid, mem_en);
            end
            cyc();
        end
        // build up a partial hold-off count, then reset must clear it
        if_req_valid = 1'b1;
        if_req_addr  = BASE + 64'h8;
        ls_req_valid = 1'b1;
        ls_req_addr  = BASE + 64'h100;
        repeat (2) cyc();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        contend("rst_cnt_clear");
    endtask

    task automatic test_back_to_back();
        bit if_fire;
        bit ls_fire;
        if_fire = 1'b1;
        ls_fire = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            cyc();
            if (if_fire || !if_req_valid) begin
                if_req_valid = ($urandom_range(0, 3) != 0);
                if_req_addr  = BASE + 64'(8 * $urandom_range(0, 15));
            end
            if (ls_fire || !ls_req_valid) begin
                ls_req_valid = ($urandom_range(0, 3) != 0);
                ls_req_addr  = BASE + 64'(8 * $urandom_range(0, 15));
                ls_req_we    = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
                ls_req_wdata = {$urandom, $urandom};
            end
            @(negedge clk);
            if_fire = if_req_valid && if_req_ready;
            ls_fire = ls_req_valid && ls_req_ready;
        end
        cyc();
        idle_inputs();
        repeat (2) cyc();
        @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got pending=%0d want 0", sb_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_cnt = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(BASE + 64'(i * 8));

        fork
            // Scoreboard monitor: checks responses, grants and memory drive.
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    total++;
                    if ({if_resp_valid, ls_resp_valid} !== 2'b00) begin
                        bad++;
                        $display("FAIL mon_rst_resp got %b%b want 00", if_resp_valid, ls_resp_valid);
                    end
                    sb_q.delete();
                    m_cnt = 0;
                end else begin
                    if (if_resp_valid === 1'b1 || ls_resp_valid === 1'b1) begin
                        total++;
                        if (sb_q.size() == 0) begin
                            bad++;
                            $display("FAIL mon_spurious got if=%b ls=%b want none",
                                     if_resp_valid, ls_resp_valid);
                        end else begin
                            m_e = sb_q.pop_front();
                            if ({if_resp_valid, ls_resp_valid} !== {m_e.is_if, !m_e.is_if}) begin
                                bad++;
                                $display("FAIL mon_port got if/ls=%b%b want %b%b", if_resp_valid,
                                         ls_resp_valid, m_e.is_if, !m_e.is_if);
                            end else if (!m_e.is_wr &&
                                         (m_e.is_if ? if_resp_data : ls_resp_data) !== m_e.data) begin
                                bad++;
                                $display("FAIL mon_data got %h want %h",
                                         m_e.is_if ? if_resp_data : ls_resp_data, m_e.data);
                            end
                        end
                    end else if (sb_q.size() != 0) begin
                        total++;
                        bad++;
                        $display("FAIL mon_missing got no resp want one");
                        sb_q.delete();
                    end

                    m_gi = if_req_valid && (!ls_req_valid || m_cnt == LIMIT);
                    m_gl = ls_req_valid && !m_gi;
                    total++;
                    if ({if_req_ready, ls_req_ready} !== {m_gi, m_gl}) begin
                        bad++;
                        $display("FAIL mon_grant got if/ls=%b%b want %b%b cnt=%0d",
                                 if_req_ready, ls_req_ready, m_gi, m_gl, m_cnt);
                    end
                    m_en   = m_gi || m_gl;
                    m_addr = m_gi ? if_req_addr : (m_gl ? ls_req_addr : 64'h0);
                    m_we   = m_gl ? ls_req_we : 8'h00;
                    total++;
                    if ({mem_en, mem_we, mem_addr, mem_wdata} !==
                        {m_en, m_we, m_addr, m_en ? ls_req_wdata : 64'h0}) begin
                        bad++;
                        $display("FAIL mon_mem got en=%b we=%h a=%h want en=%b we=%h a=%h",
                                 mem_en, mem_we, mem_addr, m_en, m_we, m_addr);
                    end

                    if (m_gi) begin
                        m_e.is_if = 1'b1;
                        m_e.is_wr = 1'b0;
                        m_e.data  = ref_mem[if_req_addr[8:3]];
                        sb_q.push_back(m_e);
                    end else if (m_gl) begin
                        m_e.is_if = 1'b0;
                        m_e.is_wr = (ls_req_we != 8'h00);
                        m_e.data  = ref_mem[ls_req_addr[8:3]];
                        sb_q.push_back(m_e);
                        if (m_e.is_wr)
                            ref_mem[ls_req_addr[8:3]] =
                                merge(ref_mem[ls_req_addr[8:3]], ls_req_wdata, ls_req_we);
                    end
                    if (if_req_valid && !m_gi) m_cnt = (m_cnt >= LIMIT) ? LIMIT : m_cnt + 1;
                    else m_cnt = 0;
                end
            end
            begin
                #2_000_000;
                $display("FAIL watchdog got timeout want finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        test_reset();
        test_if_read();
        test_ls_write_read();
        test_byte_write();
        test_starvation();
        test_reset_midflight();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
